// File: rtl/eth_phy_10g_rx_descrambler.sv
// 10GBASE-R receive descrambler (1 + x^39 + x^58) with sync-header check, one-cycle latency.
// Define ETH_PHY_10G_RX_BER_MON_EN to build the high-BER monitor; otherwise o_hi_ber is tied low.
module eth_phy_10g_rx_descrambler #(
    parameter int HDR_WIDTH         = 2,
    parameter int DATA_WIDTH        = 64,
    parameter int SCRAMBLER_DISABLE = 0,
    parameter int BER_WINDOW        = 19531,
    parameter int BER_THRESH        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HDR_WIDTH-1:0]  i_serdes_rx_hdr,
    input  logic [DATA_WIDTH-1:0] i_serdes_rx_data,
    input  logic                  i_aligned,
    output logic [HDR_WIDTH-1:0]  o_rx_hdr,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_hdr_err,
    output logic                  o_hi_ber
);

    if (HDR_WIDTH != 2 || DATA_WIDTH != 64 || BER_WINDOW < 2 || BER_WINDOW > 32768 ||
        BER_THRESH < 1 || BER_THRESH > 31) begin : g_bad_params
        $error("eth_phy_10g_rx_descrambler: unsupported parameter combination");
    end

    logic                  hdr_bad;
    logic [DATA_WIDTH-1:0] data_d;

    // Streaming stage: no backpressure, one block is accepted on every clock.
    assign hdr_bad = i_aligned &&
                     (i_serdes_rx_hdr != HDR_WIDTH'(1)) &&
                     (i_serdes_rx_hdr != HDR_WIDTH'(2));

    if (SCRAMBLER_DISABLE == 0) begin : g_descr
        logic [57:0]  state;
        logic [121:0] ext;
        logic [63:0]  desc;

        assign ext = {i_serdes_rx_data, state};

        always_comb begin
            desc = i_serdes_rx_data;
            for (int i = 0; i < 64; i++) begin
                desc[i] = desc[i] ^ ext[i+19] ^ ext[i];
            end
        end

        // History holds received (scrambled) bits and runs regardless of lock.
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= '0;
            end else begin
                state <= i_serdes_rx_data[DATA_WIDTH-1:6];
            end
        end

        assign data_d = desc;
    end else begin : g_bypass
        assign data_d = i_serdes_rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rx_hdr   <= '0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
            o_hdr_err  <= 1'b0;
        end else begin
            o_rx_hdr   <= i_serdes_rx_hdr;
            o_rx_data  <= data_d;
            o_rx_valid <= i_aligned;
            o_hdr_err  <= hdr_bad;
        end
    end

`ifdef ETH_PHY_10G_RX_BER_MON_EN
    localparam logic [14:0] WIN_LAST = 15'(BER_WINDOW - 1);
    localparam logic [4:0]  THRESH   = 5'(BER_THRESH);

    logic [14:0] win_cnt;
    logic [4:0]  err_cnt;
    logic [4:0]  err_nxt;
    logic        win_wrap;

    // An error landing on the wrap cycle is the first count of the new window.
    always_comb begin
        win_wrap = (win_cnt == WIN_LAST);
        err_nxt  = err_cnt;
        if (win_wrap) begin
            err_nxt = {4'b0, hdr_bad};
        end else if (err_cnt != THRESH) begin
            err_nxt = err_cnt + {4'b0, hdr_bad};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !i_aligned) begin
            win_cnt  <= '0;
            err_cnt  <= '0;
            o_hi_ber <= 1'b0;
        end else begin
            win_cnt  <= win_wrap ? 15'd0 : win_cnt + 15'd1;
            err_cnt  <= err_nxt;
            o_hi_ber <= (win_wrap ? (err_cnt == THRESH) : o_hi_ber) || (err_nxt == THRESH);
        end
    end
`else
    assign o_hi_ber = 1'b0;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_descrambler.sv
// Bench for eth_phy_10g_rx_descrambler: bit-serial scrambler/descrambler model and per-cycle scoreboard.
// Exercises the BER monitor too when ETH_PHY_10G_RX_BER_MON_EN is defined.
module tb_eth_phy_10g_rx_descrambler;

  localparam int WIN = 100;
  localparam int THR = 16;

  logic        clk;
  logic        rst;
  logic [1:0]  i_serdes_rx_hdr;
  logic [63:0] i_serdes_rx_data;
  logic        i_aligned;
  logic [1:0]  o_rx_hdr, pt_hdr;
  logic [63:0] o_rx_data, pt_data;
  logic        o_rx_valid, pt_valid;
  logic        o_hdr_err, pt_hdr_err;
  logic        o_hi_ber, pt_hi_ber;

  eth_phy_10g_rx_descrambler #(.BER_WINDOW(WIN), .BER_THRESH(THR)) dut (
    .clk(clk), .rst(rst),
    .i_serdes_rx_hdr(i_serdes_rx_hdr), .i_serdes_rx_data(i_serdes_rx_data), .i_aligned(i_aligned),
    .o_rx_hdr(o_rx_hdr), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
    .o_hdr_err(o_hdr_err), .o_hi_ber(o_hi_ber)
  );

  eth_phy_10g_rx_descrambler #(.SCRAMBLER_DISABLE(1), .BER_WINDOW(WIN), .BER_THRESH(THR)) dut_pt (
    .clk(clk), .rst(rst),
    .i_serdes_rx_hdr(i_serdes_rx_hdr), .i_serdes_rx_data(i_serdes_rx_data), .i_aligned(i_aligned),
    .o_rx_hdr(pt_hdr), .o_rx_data(pt_data), .o_rx_valid(pt_valid),
    .o_hdr_err(pt_hdr_err), .o_hi_ber(pt_hi_ber)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          due;
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        valid;
    logic        err;
    logic        hi;
    logic [63:0] pt;
    bit          co;
    logic [63:0] orig;
  } exp_t;

  exp_t exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("hdr",     {62'd0, o_rx_hdr},   {62'd0, e.hdr});
      chk("data",    o_rx_data,           e.data);
      chk("valid",   {63'd0, o_rx_valid}, {63'd0, e.valid});
      chk("hdr_err", {63'd0, o_hdr_err},  {63'd0, e.err});
      chk("hi_ber",  {63'd0, o_hi_ber},   {63'd0, e.hi});
      chk("pt_data", pt_data,             e.pt);
      chk("pt_valid",{63'd0, pt_valid},   {63'd0, e.valid});
      if (e.co) chk("payload", o_rx_data, e.orig);
    end
  end

  // ---------------- behavioural model ----------------
  // hist[k] is the scrambled bit received k+1 bit-times ago.
  logic [57:0] m_hist;
  int          m_pos, m_errs;
  logic        m_hi;

  function automatic logic [63:0] descr(input logic [63:0] d, input logic [57:0] h_in,
                                        output logic [57:0] h_out);
    logic [57:0] h;
    logic [63:0] o;
    h = h_in;
    for (int i = 0; i < 64; i++) begin
      o[i] = d[i] ^ h[38] ^ h[57];
      h = {h[56:0], d[i]};
    end
    h_out = h;
    return o;
  endfunction

  function automatic logic [63:0] scr(input logic [63:0] d, input logic [57:0] h_in,
                                      output logic [57:0] h_out);
    logic [57:0] h;
    logic [63:0] s;
    h = h_in;
    for (int i = 0; i < 64; i++) begin
      s[i] = d[i] ^ h[38] ^ h[57];
      h = {h[56:0], s[i]};
    end
    h_out = h;
    return s;
  endfunction

  task automatic ber_model(input logic al, input logic bad);
`ifdef ETH_PHY_10G_RX_BER_MON_EN
    if (!al) begin
      m_pos = 0; m_errs = 0; m_hi = 1'b0;
    end else begin
      if (m_pos == WIN - 1) begin
        if (m_errs < THR) m_hi = 1'b0;
        m_pos  = 0;
        m_errs = bad ? 1 : 0;
      end else begin
        m_pos++;
        m_errs = (m_errs + (bad ? 1 : 0) > THR) ? THR : m_errs + (bad ? 1 : 0);
      end
      if (m_errs >= THR) m_hi = 1'b1;
    end
`else
    m_hi = 1'b0;
    m_pos = al ? 0 : bad ? 1 : 0;
`endif
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic al, input logic [1:0] h, input logic [63:0] d,
                      input bit co, input logic [63:0] orig);
    exp_t e;
    rst = r; i_aligned = al; i_serdes_rx_hdr = h; i_serdes_rx_data = d;
    e.due = cyc + 1; e.co = 1'b0; e.orig = orig;
    if (r) begin
      m_hist = '0;
      ber_model(1'b0, 1'b0);
      e.hdr = 2'b00; e.data = '0; e.valid = 1'b0; e.err = 1'b0; e.hi = 1'b0; e.pt = '0;
    end else begin
      e.data  = descr(d, m_hist, m_hist);
      e.hdr   = h;
      e.valid = al;
      e.err   = al && (h == 2'b00 || h == 2'b11);
      ber_model(al, e.err);
      e.hi    = m_hi;
      e.pt    = d;
      e.co    = co;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    logic [57:0] sh, hx;
    logic [63:0] d, s, v;
    m_hist = '0; m_pos = 0; m_errs = 0; m_hi = 1'b0;
    rst = 1'b1; i_aligned = 1'b0; i_serdes_rx_hdr = 2'b00; i_serdes_rx_data = '0;
    @(posedge clk);
    #1;

    // Hand-computed pins on the model itself.
    v = descr(64'h1, 58'd0, hx);
    chk("pin_descr_first", v, 64'h0400_0080_0000_0001);
    v = descr(64'h0, hx, hx);
    chk("pin_descr_second", v, 64'h0);
    v = scr(64'h1, 58'd0, hx);
    chk("pin_scr_first", v, 64'h0400_0080_0000_0001);

    // Reset, then the basic impulse block.
    repeat (2) step(1, 0, 2'b00, rand64(), 0, 0);
    step(0, 1, 2'b10, 64'h0000_0000_0000_0001, 0, 0);
    step(0, 1, 2'b10, 64'h0, 0, 0);

    // Scrambled random traffic: payload recovered from the second block on.
    sh = {$urandom(), $urandom()} | 58'd1;
    for (int n = 0; n < 1000; n++) begin
      d = rand64();
      s = scr(d, sh, sh);
      step(0, 1, good_hdr(), s, n > 0, d);
    end

    // Invalid header while aligned, then while unaligned.
    step(0, 1, 2'b11, rand64(), 0, 0);
    step(0, 0, 2'b00, rand64(), 0, 0);
    step(0, 1, 2'b10, rand64(), 0, 0);

`ifdef ETH_PHY_10G_RX_BER_MON_EN
    step(0, 0, 2'b10, rand64(), 0, 0);
    for (int k = 0; k < 2 * WIN; k++) begin
      logic bad;
      bad = (k < 80 && k % 5 == 0) || k == 110 || k == 130 || k == 150;
      step(0, 1, bad ? (k[0] ? 2'b11 : 2'b00) : good_hdr(), rand64(), 0, 0);
      if (k == 75) chk("model_hi_set", {63'd0, m_hi}, 64'd1);
      if (k == 2 * WIN - 1) chk("model_hi_clear", {63'd0, m_hi}, 64'd0);
    end
    step(0, 1, 2'b00, rand64(), 0, 0);
    step(0, 0, 2'b10, rand64(), 0, 0);
`endif

    // Pass-through instance value.
    step(0, 1, 2'b01, 64'hDEAD_BEEF_0123_4567, 0, 0);

    // Mid-stream reset with non-zero history, then the impulse again.
    repeat (4) step(0, 1, good_hdr(), rand64(), 0, 0);
    step(1, 0, 2'b10, rand64(), 0, 0);
    step(0, 1, 2'b10, 64'h0000_0000_0000_0001, 0, 0);
    step(0, 1, 2'b10, 64'h0, 0, 0);

    // Random mix of headers, lock and occasional reset.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
           2'($urandom_range(0, 3)), rand64(), 0, 0);
    end
    step(0, 0, 2'b00, '0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
